dvp_camera_emulator: RTL
========================

// Module: dvp_camera_emulator
// PURPOSE
// - OV7670-style DVP pixel source: drives xclk-domain vsync/href/pclk/data[7:0] exactly as a camera does, so each
//   capture buffer and the four-window VGA compositor can be exercised on-board and in simulation without sensors.
// - Transmit end of the camera parallel interface; output pins wire straight to a capture buffer's vsync/href/pclk/data.
// - Emits RGB565 frames, high byte first, from a selectable built-in test pattern; one clock domain (clk_24).
// PARAMETERS
// - H_ACTIVE  174  active pixels per line (each pixel = 2 bytes)
// - V_ACTIVE  144  active lines per frame
// - H_BLANK   32   byte slots per line with href low, after the active bytes
// - V_SYNC    3    lines with vsync high at frame start
// - V_BACK    17   blank lines after vsync, before the first active line
// - V_FRONT   10   blank lines after the last active line
// - BAR_W     22   pixels per colour bar (pattern 0)
// PORTS
// - clk_24     in   1   24 MHz system camera clock; all logic on its rising edge
// - reset      in   1   synchronous, active-high reset
// - enable     in   1   start/continue frame generation
// - pwdn       in   1   power-down: immediate idle, all outputs low
// - pattern    in   2   0 colour bars, 1 gradient, 2 checker 8x8, 3 coordinate ID
// - vsync      out  1   frame sync, high for V_SYNC lines
// - href       out  1   high while active bytes are on data
// - pclk       out  1   pixel clock = clk_24/2 while running; low when idle
// - data       out  8   pixel byte, changes only on pclk falling edge
// - frame_cnt  out  16  completed-frame counter, wraps 0xFFFF->0
// - busy       out  1   high from IDLE exit until return to IDLE
// BEHAVIOUR
// - Reset: vsync=0, href=0, pclk=0, data=0, frame_cnt=0, busy=0, state IDLE, all counters 0. Reset mid-frame aborts
//   immediately; the next frame restarts from VSYNC.
// - pclk toggles every clk_24 cycle while busy. A byte slot = 2 cycles; vsync/href/data update only in the cycle
//   pclk goes 1->0, so they are stable at every pclk rising edge (the receiver's sampling edge).
// - Line = 2*H_ACTIVE + H_BLANK byte slots (380 default). Frame = V_SYNC+V_BACK+V_ACTIVE+V_FRONT lines (174).
// - FSM: IDLE -(enable & ~pwdn)-> VSYNC -(V_SYNC lines)-> VBACK -(V_BACK)-> ACTIVE -(V_ACTIVE)-> VFRONT
//   -(V_FRONT)-> VSYNC if enable, else IDLE. pwdn=1 in any state -> IDLE next cycle, outputs 0. V_BACK=0 or
//   V_FRONT=0 skips that state.
// - vsync=1 exactly in VSYNC. href=1 only in ACTIVE, during the first 2*H_ACTIVE byte slots of each line.
// - Byte order: even slot = pix[15:8], odd slot = pix[7:0]. data=0 whenever href=0.
// - enable deasserted mid-frame: the current frame completes through VFRONT, then IDLE (no truncated frame).
// - pattern sampled on VSYNC entry, held for the whole frame; mid-frame changes take effect next frame.
// - frame_cnt increments on the last cycle of VFRONT (including when going to IDLE).
// - Patterns (x = pixel 0..H_ACTIVE-1, y = active line 0..V_ACTIVE-1):
//   0: bar = min(x/BAR_W,7) via counter, no divider; colours W FFFF, Y FFE0, C 07FF, G 07E0, M F81F, R F800,
//      B 001F, K 0000
//   1: {x[4:0], y[5:0], frame_cnt[4:0]}
//   2: (x[3]^y[3]) ? 16'hFFFF : 16'h0000
//   3: {y[7:0], x[7:0]}   (address-check pattern)
// - Counters sized by $clog2 of their maxima; no wrap inside a frame; x and bar counters reset at each line start.
// STRUCTURE
// - Package dvp_emu_pkg: pattern enum, FSM state enum, RGB565 bar colour constants, default timing localparams.
// - Sub-module dvp_pattern_gen: (pattern, x, y, bar, frame_cnt) -> 16-bit pixel, registered one byte slot ahead,
//   so the FSM only selects the high or low byte.
// - Top: FSM, pclk toggle, slot/line/frame counters, output registers.
// TESTING
// - Reset, enable=1, pattern=3: first href rise after 3 vsync lines + 17 blank lines; bytes 00,00,00,01,...,00,AD
//   (x=173); last line y=143 gives 8F,AD.
// - Timing: per line 348 href-high pclk rises + 32 low; 144 href lines between vsync pulses; vsync high 3*380*2
//   clk_24 cycles; data never changes on a pclk rising-edge cycle.
// - Pattern 0: pixels 0..21 = FFFF, 22..43 = FFE0, pixels 154..173 = 0000 (bar clamped at 7).
// - Pattern switch 2->1 mid-ACTIVE: current frame stays all checker; next frame is gradient, B field = frame_cnt.
// - enable dropped at line 50: frame finishes all 144 lines, frame_cnt +1, busy falls, pclk stays 0.
// - pwdn or reset pulsed mid-line: next cycle all outputs 0; after release, a fresh VSYNC frame is bit-identical
//   to a post-reset frame.

Source files
------------

// File: rtl/dvp_emu_pkg.sv
// Shared types and defaults for the DVP camera emulator: pattern and FSM enums, RGB565 bar colours,
// default frame timing.
package dvp_emu_pkg;

    localparam int unsigned DefHActive = 174;
    localparam int unsigned DefVActive = 144;
    localparam int unsigned DefHBlank  = 32;
    localparam int unsigned DefVSync   = 3;
    localparam int unsigned DefVBack   = 17;
    localparam int unsigned DefVFront  = 10;
    localparam int unsigned DefBarW    = 22;

    typedef enum logic [1:0] {
        PatBars     = 2'd0,
        PatGradient = 2'd1,
        PatChecker  = 2'd2,
        PatCoord    = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    localparam logic [15:0] ColWhite   = 16'hFFFF;
    localparam logic [15:0] ColYellow  = 16'hFFE0;
    localparam logic [15:0] ColCyan    = 16'h07FF;
    localparam logic [15:0] ColGreen   = 16'h07E0;
    localparam logic [15:0] ColMagenta = 16'hF81F;
    localparam logic [15:0] ColRed     = 16'hF800;
    localparam logic [15:0] ColBlue    = 16'h001F;
    localparam logic [15:0] ColBlack   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] col;
        unique case (bar)
            3'd0: col = ColWhite;
            3'd1: col = ColYellow;
            3'd2: col = ColCyan;
            3'd3: col = ColGreen;
            3'd4: col = ColMagenta;
            3'd5: col = ColRed;
            3'd6: col = ColBlue;
            3'd7: col = ColBlack;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/dvp_camera_emulator_if.sv
// Camera-side DVP bus: the emulator drives it as master, a capture buffer listens as slave.
interface dvp_camera_emulator_if;
    logic       vsync;
    logic       href;
    logic       pclk;
    logic [7:0] data;

    modport master (output vsync, href, pclk, data);
    modport slave  (input  vsync, href, pclk, data);
endinterface

// File: rtl/dvp_pattern_gen.sv
// Test-pattern pixel source; the pixel for the coordinates on its inputs is registered so the top only
// has to pick the high or low byte when the slot goes onto the bus.
module dvp_pattern_gen
    import dvp_emu_pkg::*;
#(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  pattern_e      pattern_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [2:0]    bar_i,
    input  logic [4:0]    frame_cnt_i,
    output logic [15:0]   pix_o
);

    logic [7:0]  x8;
    logic [7:0]  y8;
    logic [15:0] pix_d;
    logic [15:0] pix_q;

    always_comb begin
        x8    = 8'(x_i);
        y8    = 8'(y_i);
        pix_d = 16'h0000;
        unique case (pattern_i)
            PatBars:     pix_d = bar_color(bar_i);
            PatGradient: pix_d = {x8[4:0], y8[5:0], frame_cnt_i};
            PatChecker:  pix_d = (x8[3] ^ y8[3]) ? 16'hFFFF : 16'h0000;
            PatCoord:    pix_d = {y8, x8};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pix_q <= 16'h0000;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/dvp_camera_emulator.sv
// OV7670-style DVP pixel source: frame FSM, pclk generation, slot/line counters and registered bus outputs.
// Counters hold the position of the next byte slot; it is put on the bus on the pclk falling edge.
module dvp_camera_emulator
    import dvp_emu_pkg::*;
#(
    parameter int unsigned HActive = DefHActive,
    parameter int unsigned VActive = DefVActive,
    parameter int unsigned HBlank  = DefHBlank,
    parameter int unsigned VSync   = DefVSync,
    parameter int unsigned VBack   = DefVBack,
    parameter int unsigned VFront  = DefVFront,
    parameter int unsigned BarW    = DefBarW
) (
    input  logic                        clk_24,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        pwdn,
    input  logic [1:0]                  pattern,
    output logic [15:0]                 frame_cnt,
    output logic                        busy,
    dvp_camera_emulator_if.master       dvp
);

    localparam int unsigned LineSlots = 2 * HActive + HBlank;
    localparam int unsigned MaxSB     = (VSync > VBack) ? VSync : VBack;
    localparam int unsigned MaxAF     = (VActive > VFront) ? VActive : VFront;
    localparam int unsigned MaxLines  = (MaxSB > MaxAF) ? MaxSB : MaxAF;
    localparam int unsigned SlotW     = $clog2(LineSlots);
    localparam int unsigned LineW     = $clog2(MaxLines);
    localparam int unsigned XW        = $clog2(HActive);
    localparam int unsigned BarCntW   = $clog2(BarW);

    state_e               state_q, state_d, next_state;
    pattern_e             pattern_q, pattern_d;
    logic                 pclk_q, pclk_d;
    logic                 busy_q, busy_d;
    logic                 vsync_q, vsync_d;
    logic                 href_q, href_d;
    logic [7:0]           data_q, data_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [SlotW-1:0]     slot_q, slot_d;
    logic [LineW-1:0]     line_q, line_d;
    logic [XW-1:0]        x_q, x_d;
    logic [2:0]           bar_q, bar_d;
    logic [BarCntW-1:0]   bar_cnt_q, bar_cnt_d;
    logic                 last_slot;
    logic                 last_line;
    logic [15:0]          pix;

    dvp_pattern_gen #(
        .XW (XW),
        .YW (LineW)
    ) u_pattern_gen (
        .clk_i       (clk_24),
        .reset_i     (reset),
        .pattern_i   (pattern_q),
        .x_i         (x_q),
        .y_i         (line_q),
        .bar_i       (bar_q),
        .frame_cnt_i (frame_cnt_q[4:0]),
        .pix_o       (pix)
    );

    // Zero-length blanking periods are skipped; StIdle as successor marks the end of a frame.
    always_comb begin
        last_slot  = (slot_q == SlotW'(LineSlots - 1));
        last_line  = 1'b0;
        next_state = StIdle;
        case (state_q)
            StVsync: begin
                last_line  = (line_q == LineW'(VSync - 1));
                next_state = (VBack != 0) ? StVback : StActive;
            end
            StVback: begin
                last_line  = (line_q == LineW'(VBack - 1));
                next_state = StActive;
            end
            StActive: begin
                last_line  = (line_q == LineW'(VActive - 1));
                next_state = (VFront != 0) ? StVfront : StIdle;
            end
            StVfront: begin
                last_line  = (line_q == LineW'(VFront - 1));
                next_state = StIdle;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        pclk_d      = pclk_q;
        busy_d      = busy_q;
        vsync_d     = vsync_q;
        href_d      = href_q;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        slot_d      = slot_q;
        line_d      = line_q;
        x_d         = x_q;
        bar_d       = bar_q;
        bar_cnt_d   = bar_cnt_q;

        if (pwdn) begin
            state_d   = StIdle;
            pclk_d    = 1'b0;
            busy_d    = 1'b0;
            vsync_d   = 1'b0;
            href_d    = 1'b0;
            data_d    = 8'h00;
            slot_d    = '0;
            line_d    = '0;
            x_d       = '0;
            bar_d     = '0;
            bar_cnt_d = '0;
        end else if (state_q == StIdle) begin
            pclk_d = 1'b0;
            if (enable) begin
                // Leaving idle puts the first VSYNC slot on the bus straight away.
                state_d   = StVsync;
                pattern_d = pattern_e'(pattern);
                busy_d    = 1'b1;
                vsync_d   = 1'b1;
                href_d    = 1'b0;
                data_d    = 8'h00;
                slot_d    = SlotW'(1);
                line_d    = '0;
                x_d       = '0;
                bar_d     = '0;
                bar_cnt_d = '0;
            end
        end else begin
            pclk_d = ~pclk_q;
            if (pclk_q) begin
                vsync_d = (state_q == StVsync);
                href_d  = (state_q == StActive) && (slot_q < SlotW'(2 * HActive));
                data_d  = href_d ? (slot_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
                if (last_slot) begin
                    slot_d    = '0;
                    x_d       = '0;
                    bar_d     = '0;
                    bar_cnt_d = '0;
                    if (last_line) begin
                        line_d = '0;
                        if (next_state == StIdle) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            if (enable) begin
                                state_d   = StVsync;
                                pattern_d = pattern_e'(pattern);
                            end else begin
                                state_d = StIdle;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            state_d = next_state;
                        end
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                    if (slot_q[0] && (slot_q < SlotW'(2 * HActive - 1))) begin
                        x_d = x_q + 1'b1;
                        if (bar_cnt_q == BarCntW'(BarW - 1)) begin
                            bar_cnt_d = '0;
                            if (bar_q != 3'd7) begin
                                bar_d = bar_q + 1'b1;
                            end
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_24) begin
        if (reset) begin
            state_q     <= StIdle;
            pattern_q   <= PatBars;
            pclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            frame_cnt_q <= 16'h0000;
            slot_q      <= '0;
            line_q      <= '0;
            x_q         <= '0;
            bar_q       <= '0;
            bar_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            pclk_q      <= pclk_d;
            busy_q      <= busy_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
            slot_q      <= slot_d;
            line_q      <= line_d;
            x_q         <= x_d;
            bar_q       <= bar_d;
            bar_cnt_q   <= bar_cnt_d;
        end
    end

    assign dvp.vsync = vsync_q;
    assign dvp.href  = href_q;
    assign dvp.pclk  = pclk_q;
    assign dvp.data  = data_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;

endmodule
